// File: rtl/cnn_cfg_master.sv
// Configuration master for the CNN accelerator register block.
// On each launch it programs the input and output bases and sets CTRL.start.
// It then waits for done_i, with a timeout, and reads STATUS back.
// Transfers go out over an OBI master port with at most one in flight.
//
// state      | meaning
// -----------+--------------------------------------------------
// IDLE       | waiting for start_i
// WR_IN      | write INPUT_BASE  (+0x08)
// WR_OUT     | write OUTPUT_BASE (+0x0C)
// WR_CTRL    | write CTRL (+0x00) = 1
// WAIT_DONE  | count cycles until done_i or timeout
// RD_STAT    | read STATUS (+0x04) into status_o
// FINISH     | one-cycle finish_o pulse
//
// Each bus state has a request phase (resp_q=0, req held until gnt) and a
// response phase (resp_q=1, waiting for rvalid).
module cnn_cfg_master #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0,
  parameter int unsigned            TIMEOUT    = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] input_base_i,
  input  logic [ADDR_WIDTH-1:0] output_base_i,
  output logic                  obi_req_o,
  output logic                  obi_we_o,
  output logic [ADDR_WIDTH-1:0] obi_addr_o,
  output logic [DATA_WIDTH-1:0] obi_wdata_o,
  output logic [3:0]            obi_aid_o,
  input  logic                  obi_gnt_i,
  input  logic                  obi_rvalid_i,
  input  logic [DATA_WIDTH-1:0] obi_rdata_i,
  input  logic                  obi_err_i,
  input  logic                  done_i,
  output logic                  busy_o,
  output logic                  finish_o,
  output logic [1:0]            err_o,
  output logic [DATA_WIDTH-1:0] status_o
);

  localparam int unsigned     CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_IN, S_WR_OUT, S_WR_CTRL, S_WAIT_DONE, S_RD_STAT, S_FINISH
  } state_e;

  state_e                state_q, state_d;
  logic                  resp_q, resp_d;
  logic [ADDR_WIDTH-1:0] in_base_q, in_base_d;
  logic [ADDR_WIDTH-1:0] out_base_q, out_base_d;
  logic [3:0]            aid_q, aid_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            err_q, err_d;
  logic [DATA_WIDTH-1:0] status_q, status_d;
  logic                  bus_active;
  logic                  gnt_now;
  state_e                next_step;

  // State and datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      resp_q     <= 1'b0;
      in_base_q  <= '0;
      out_base_q <= '0;
      aid_q      <= '0;
      cnt_q      <= '0;
      err_q      <= '0;
      status_q   <= '0;
    end else begin
      state_q    <= state_d;
      resp_q     <= resp_d;
      in_base_q  <= in_base_d;
      out_base_q <= out_base_d;
      aid_q      <= aid_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      status_q   <= status_d;
    end
  end

  // Next-state, bus handshake and output decode.
  always_comb begin
    state_d      = state_q;
    resp_d       = resp_q;
    in_base_d    = in_base_q;
    out_base_d   = out_base_q;
    aid_d        = aid_q;
    cnt_d        = '0;
    err_d        = err_q;
    status_d     = status_q;
    next_step    = S_IDLE;
    bus_active   = 1'b0;
    gnt_now      = 1'b0;
    obi_we_o     = 1'b0;
    obi_addr_o   = '0;
    obi_wdata_o  = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          in_base_d  = input_base_i;
          out_base_d = output_base_i;
          err_d      = 2'd0;
          status_d   = '0;
          resp_d     = 1'b0;
          state_d    = S_WR_IN;
        end
      end
      S_WR_IN: begin
        bus_active  = 1'b1;
        next_step   = S_WR_OUT;
        obi_we_o    = 1'b1;
        obi_addr_o  = BASE_ADDR + ADDR_WIDTH'(32'h8);
        obi_wdata_o = DATA_WIDTH'(in_base_q);
      end
      S_WR_OUT: begin
        bus_active  = 1'b1;
        next_step   = S_WR_CTRL;
        obi_we_o    = 1'b1;
        obi_addr_o  = BASE_ADDR + ADDR_WIDTH'(32'hC);
        obi_wdata_o = DATA_WIDTH'(out_base_q);
      end
      S_WR_CTRL: begin
        bus_active  = 1'b1;
        next_step   = S_WAIT_DONE;
        obi_we_o    = 1'b1;
        obi_addr_o  = BASE_ADDR;
        obi_wdata_o = DATA_WIDTH'(32'h1);
      end
      S_WAIT_DONE: begin
        if (done_i) begin
          state_d = S_RD_STAT;
          resp_d  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 2'd2;
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RD_STAT: begin
        bus_active = 1'b1;
        next_step  = S_FINISH;
        obi_addr_o = BASE_ADDR + ADDR_WIDTH'(32'h4);
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // A grant and rvalid in the same cycle complete the transfer at once.
    if (bus_active) begin
      gnt_now = !resp_q && obi_gnt_i;
      if (gnt_now) aid_d = aid_q + 4'd1;
      if ((resp_q || gnt_now) && obi_rvalid_i) begin
        resp_d = 1'b0;
        if (state_q == S_RD_STAT) status_d = obi_rdata_i;
        if (obi_err_i) begin
          err_d   = 2'd1;
          state_d = S_FINISH;
        end else begin
          state_d = next_step;
        end
      end else if (gnt_now) begin
        resp_d = 1'b1;
      end
    end
  end

  assign obi_req_o = bus_active && !resp_q;
  assign obi_aid_o = aid_q;
  assign busy_o    = (state_q != S_IDLE);
  assign finish_o  = (state_q == S_FINISH);
  assign err_o     = err_q;
  assign status_o  = status_q;

endmodule
